macc_dot: RTL and testbench

- Parametrised successor to the team's streaming signed MAC: accumulates signed products of a/b sample pairs over frames of programmable length.
- Emits one result per frame, with a valid strobe.
- Frame start is automatic (internal sample counter), so the external sload input is not needed.
- Sits between sample sources (filters, correlators) and result consumers that sample on out_valid.

---
 rtl/macc_dot.sv | 187 ++++++++++++++++++
 tb/tb_macc_dot.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/macc_dot.sv
// macc_dot: streaming signed dot-product engine. Accumulates a*b products
// over frames whose length is taken from len on each frame's first sample,
// and emits one result per frame with a single-cycle valid strobe.
// Optional saturating accumulation: define MACC_DOT_SAT_EN.
module macc_dot #(
  parameter int SIZEIN  = 16,
  parameter int SIZEOUT = 40,
  parameter int LEN_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic signed [SIZEIN-1:0]  a,
  input  logic signed [SIZEIN-1:0]  b,
  input  logic        [LEN_W-1:0]   len,
  output logic                      out_valid,
  output logic signed [SIZEOUT-1:0] accum_out,
  output logic                      sat
);

  localparam int PW = 2 * SIZEIN;

`ifdef MACC_DOT_SAT_EN
  localparam logic [SIZEOUT-1:0] ACC_MAX = {1'b0, {(SIZEOUT-1){1'b1}}};
  localparam logic [SIZEOUT-1:0] ACC_MIN = {1'b1, {(SIZEOUT-1){1'b0}}};

  // Returns {clip, value}: the sum clamped to the signed SIZEOUT range.
  function automatic logic [SIZEOUT:0] sat_add(
    input logic signed [SIZEOUT-1:0] x,
    input logic signed [SIZEOUT-1:0] y
  );
    logic signed [SIZEOUT:0] s;
    s = {x[SIZEOUT-1], x} + {y[SIZEOUT-1], y};
    if (s[SIZEOUT] != s[SIZEOUT-1])
      return {1'b1, (s[SIZEOUT] ? ACC_MIN : ACC_MAX)};
    else
      return {1'b0, s[SIZEOUT-1:0]};
  endfunction
`endif

  // Frame sequencing
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] eff_len;
  logic             accept, first_s, last_s;

  // Stage 1 registers
  logic signed [SIZEIN-1:0] a_p1_q, b_p1_q;
  logic                     vld_p1_q, first_p1_q, last_p1_q;

  // Stage 2 registers
  logic signed [PW-1:0]     prod_p2_q;
  logic                     vld_p2_q, first_p2_q, last_p2_q;

  // Stage 3 registers
  logic signed [SIZEOUT-1:0] acc_q, acc_d, accum_q;
  logic signed [SIZEOUT-1:0] prod_ext, acc_base;
  logic                      out_valid_q, load_s3;

  // Frame counter next state; a zero length is treated as a single-sample frame
  always_comb begin
    accept  = ce & in_valid & ~clr;
    first_s = (cnt_q == '0);
    if (first_s)
      eff_len = (len == '0) ? LEN_W'(1) : len;
    else
      eff_len = len_q;
    last_s = (cnt_q == (eff_len - LEN_W'(1)));
    cnt_d  = cnt_q;
    len_d  = len_q;
    if (clr) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last_s ? '0 : (cnt_q + LEN_W'(1));
      if (first_s)
        len_d = eff_len;
    end
  end

  // Counter and latched frame length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (ce) begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  // ---- Stage 1: capture sample and frame position ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1_q     <= '0;
      b_p1_q     <= '0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
    end else if (ce) begin
      vld_p1_q <= accept;
      if (accept) begin
        a_p1_q     <= a;
        b_p1_q     <= b;
        first_p1_q <= first_s;
        last_p1_q  <= last_s;
      end
    end
  end

  // ---- Stage 2: full-precision product ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p2_q  <= '0;
      vld_p2_q   <= 1'b0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
    end else if (ce) begin
      prod_p2_q  <= a_p1_q * b_p1_q;
      vld_p2_q   <= vld_p1_q & ~clr;
      first_p2_q <= first_p1_q;
      last_p2_q  <= last_p1_q;
    end
  end

  // ---- Stage 3: accumulate; a first sample restarts the sum ----
`ifdef MACC_DOT_SAT_EN
  logic [SIZEOUT:0] add_r;
  logic             clip, flag_q, flag_d, sat_q;
`endif

  // Accumulator next value (wrapping or saturating)
  always_comb begin
    load_s3  = vld_p2_q & ~clr;
    prod_ext = SIZEOUT'(prod_p2_q);
    acc_base = first_p2_q ? '0 : acc_q;
`ifdef MACC_DOT_SAT_EN
    add_r  = sat_add(acc_base, prod_ext);
    clip   = add_r[SIZEOUT];
    acc_d  = add_r[SIZEOUT-1:0];
    flag_d = (first_p2_q ? 1'b0 : flag_q) | clip;
`else
    acc_d  = acc_base + prod_ext;
`endif
  end

  // Accumulator, result register and result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      accum_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      out_valid_q <= 1'b0;
      if (load_s3) begin
        acc_q <= acc_d;
        if (last_p2_q) begin
          accum_q     <= acc_d;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef MACC_DOT_SAT_EN
  // Sticky per-frame clip flag, published with each result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (ce && load_s3) begin
      flag_q <= flag_d;
      if (last_p2_q)
        sat_q <= flag_d;
    end
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign accum_out = accum_q;

endmodule

// File: tb/tb_macc_dot.sv
// Directed bench for macc_dot (SIZEOUT=32 so the overflow case is reachable).
module tb_macc_dot;

  localparam int SIZEIN  = 16;
  localparam int SIZEOUT = 32;
  localparam int LEN_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst_n, ce, clr, in_valid;
  logic signed [SIZEIN-1:0]  a, b;
  logic        [LEN_W-1:0]   len;
  logic                      out_valid, sat;
  logic signed [SIZEOUT-1:0] accum_out;

  macc_dot #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .len(len), .out_valid(out_valid),
    .accum_out(accum_out), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct { longint v; bit s; int stamp; } res_t;
  res_t res_q[$];

  int  edges = 0;
  int  last_edge = 0;
  bit  last_ce = 1'b0;
  int  vectors = 0;
  int  miscompares = 0;

  always @(posedge clk) begin
    edges   <= edges + 1;
    last_ce <= ce;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && last_ce) begin
      res_t r;
      r.v = longint'(accum_out);
      r.s = sat;
      r.stamp = edges;
      res_q.push_back(r);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit ce_v, input bit clr_v, input bit vld,
                      input int av, input int bv, input int lv);
    ce = ce_v; clr = clr_v; in_valid = vld;
    a = SIZEIN'(av); b = SIZEIN'(bv); len = LEN_W'(lv);
    @(posedge clk);
    #1;
    if (vld && ce_v && !clr_v) last_edge = edges;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Wait for the next result, compare value, sat and (if lat>=0) latency
  task automatic expect_res(input string tag, input longint v, input bit s, input int lat);
    int n = 0;
    res_t r;
    while (res_q.size() == 0 && n < 20) begin
      idle(1);
      n++;
    end
    if (res_q.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      r = res_q.pop_front();
      check({tag, "_val"}, r.v, v);
      check({tag, "_sat"}, longint'(r.s), longint'(s));
      if (lat >= 0) check({tag, "_lat"}, r.stamp - last_edge, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; len = '0;
    #22;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_accum", longint'(accum_out), 0);
    check("rst_sat", longint'(sat), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Basic frame: 12 - 10 - 7 = -5, result 2 edges after the last sample edge
    step(1, 0, 1, 3, 4, 3);
    step(1, 0, 1, -2, 5, 3);
    step(1, 0, 1, 7, -1, 3);
    expect_res("basic", -5, 0, 2);
    idle(4);
    check("basic_single_pulse", res_q.size(), 0);

    // Gap inside a frame, then back-to-back frame
    step(1, 0, 1, 2, 2, 2);
    step(1, 0, 0, 9, 9, 2);
    step(1, 0, 1, 3, 3, 2);
    step(1, 0, 1, 1, 1, 2);
    step(1, 0, 1, 1, 1, 2);
    expect_res("gap", 13, 0, -1);
    expect_res("b2b", 2, 0, -1);
    idle(3);

    // Asynchronous reset mid-frame (cnt=2 of len=4)
    step(1, 0, 1, 1, 1, 4);
    step(1, 0, 1, 1, 1, 4);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", longint'(out_valid), 0);
    check("async_rst_accum", longint'(accum_out), 0);
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 1, 4);
    expect_res("post_rst", 4, 0, 2);
    idle(2);

    // ce stall of 5 cycles: 2 + 12 + 30 = 44, delayed by 5
    step(1, 0, 1, 1, 2, 3);
    step(1, 0, 1, 3, 4, 3);
    step(1, 0, 1, 5, 6, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    expect_res("stall", 44, 0, 7);
    idle(2);

    // clr after one sample drops the frame; in_valid with clr is ignored
    step(1, 0, 1, 9, 9, 3);
    step(1, 1, 1, 8, 8, 3);
    idle(5);
    check("clr_no_result", res_q.size(), 0);
    check("clr_accum_held", longint'(accum_out), 44);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 5, 5, 3);
    expect_res("after_clr", 75, 0, 2);
    idle(2);

    // len=0 behaves as single-sample frames
    step(1, 0, 1, -32768, -32768, 0);
    step(1, 0, 1, -32768, -32768, 0);
    expect_res("len0_a", 1073741824, 0, -1);
    expect_res("len0_b", 1073741824, 0, -1);
    idle(2);

    // Overflow of the 32-bit accumulator
    for (int i = 0; i < 3; i++) step(1, 0, 1, -32768, -32768, 3);
`ifdef MACC_DOT_SAT_EN
    expect_res("ovf", 2147483647, 1, 2);
`else
    expect_res("ovf", -1073741824, 0, 2);
`endif
    // Next frame starts clean: sat flag cleared by the first sample
    step(1, 0, 1, 1, 1, 1);
    expect_res("post_ovf", 1, 0, 2);
    idle(3);
    check("no_extra_results", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
